// File: rtl/exe_module_if.sv
// ID/EXE -> EXE -> EXE/MEM signal bundle for the execute stage.
// Signal names follow the pipeline's established port names.
interface exe_module_if;
  logic        freeze;
  logic        wb_enable_in;
  logic        mem_read_enable_in;
  logic        mem_write_enable_in;
  logic        branch_enable_in;
  logic        S_in;
  logic [3:0]  exec_cmd;
  logic [31:0] PC_in;
  logic [31:0] Val_Rn;
  logic [31:0] Val_Rm;
  logic        immidiate;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_immidiate_24;
  logic [3:0]  Dest_in;

  logic [3:0]  status;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        wb_enable;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] ALU_result;
  logic [31:0] Val_Rm_out;
  logic [3:0]  Dest;

  // Execute stage side.
  modport slave (
    input  freeze, wb_enable_in, mem_read_enable_in, mem_write_enable_in,
           branch_enable_in, S_in, exec_cmd, PC_in, Val_Rn, Val_Rm, immidiate,
           Shift_operand, Signed_immidiate_24, Dest_in,
    output status, branch_taken, branch_address, wb_enable, mem_read_enable,
           mem_write_enable, ALU_result, Val_Rm_out, Dest
  );

  // Driver / pipeline-neighbour side.
  modport master (
    output freeze, wb_enable_in, mem_read_enable_in, mem_write_enable_in,
           branch_enable_in, S_in, exec_cmd, PC_in, Val_Rn, Val_Rm, immidiate,
           Shift_operand, Signed_immidiate_24, Dest_in,
    input  status, branch_taken, branch_address, wb_enable, mem_read_enable,
           mem_write_enable, ALU_result, Val_Rm_out, Dest
  );
endinterface

// File: rtl/exe_module.sv
// Execute stage: Val2 shifter, ALU with NZCV flags, branch target adder,
// status register and the EXE/MEM pipeline register.
module exe_module #(
  parameter int unsigned WIDTH = 32
) (
  input logic   clk,
  input logic   rst,
  exe_module_if.slave bus
);

  typedef enum logic [3:0] {
    CmdMov = 4'b0001,
    CmdAdd = 4'b0010,
    CmdAdc = 4'b0011,
    CmdSub = 4'b0100,
    CmdSbc = 4'b0101,
    CmdAnd = 4'b0110,
    CmdOrr = 4'b0111,
    CmdEor = 4'b1000,
    CmdMvn = 4'b1001
  } alu_cmd_e;

  logic [3:0]       status_q;
  logic [3:0]       flags_nxt;
  logic [WIDTH-1:0] val2;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   sum;
  logic             op_valid;
  logic [4:0]       sh_amt;

  logic             wb_q;
  logic             mem_rd_q;
  logic             mem_wr_q;
  logic [WIDTH-1:0] alu_q;
  logic [WIDTH-1:0] rm_q;
  logic [3:0]       dest_q;

  // Rotate right; an amount of zero returns the operand untouched.
  function automatic logic [WIDTH-1:0] ror_w(input logic [WIDTH-1:0] x, input logic [4:0] amt);
    if (amt == 5'd0) begin
      return x;
    end
    return (x >> amt) | (x << (6'd32 - {1'b0, amt}));
  endfunction

  assign sh_amt = bus.Shift_operand[11:7];

  // Second operand: rotated immediate, memory offset, or shifted register.
  always_comb begin
    val2 = '0;
    if (bus.immidiate) begin
      val2 = ror_w({24'd0, bus.Shift_operand[7:0]}, {bus.Shift_operand[11:8], 1'b0});
    end else if (bus.mem_read_enable_in || bus.mem_write_enable_in) begin
      val2 = {20'd0, bus.Shift_operand};
    end else begin
      case (bus.Shift_operand[6:5])
        2'b00:   val2 = bus.Val_Rm << sh_amt;
        2'b01:   val2 = bus.Val_Rm >> sh_amt;
        2'b10:   val2 = $unsigned($signed(bus.Val_Rm) >>> sh_amt);
        default: val2 = ror_w(bus.Val_Rm, sh_amt);
      endcase
    end
  end

  // ALU core and next flags; unknown opcodes yield 0 and keep all flags.
  always_comb begin
    alu_res   = '0;
    sum       = '0;
    op_valid  = 1'b1;
    flags_nxt = status_q;
    case (bus.exec_cmd)
      CmdMov: alu_res = val2;
      CmdMvn: alu_res = ~val2;
      CmdAnd: alu_res = bus.Val_Rn & val2;
      CmdOrr: alu_res = bus.Val_Rn | val2;
      CmdEor: alu_res = bus.Val_Rn ^ val2;
      CmdAdd, CmdAdc: begin
        sum = {1'b0, bus.Val_Rn} + {1'b0, val2} +
              {{WIDTH{1'b0}}, (bus.exec_cmd == CmdAdc) & status_q[1]};
        alu_res      = sum[WIDTH-1:0];
        flags_nxt[1] = sum[WIDTH];
        flags_nxt[0] = (bus.Val_Rn[WIDTH-1] == val2[WIDTH-1]) &&
                       (alu_res[WIDTH-1] != bus.Val_Rn[WIDTH-1]);
      end
      CmdSub, CmdSbc: begin
        // Rn + ~Val2 + carry-in: carry-out is the ARM "not borrow".
        sum = {1'b0, bus.Val_Rn} + {1'b0, ~val2} +
              {{WIDTH{1'b0}}, (bus.exec_cmd == CmdSub) | status_q[1]};
        alu_res      = sum[WIDTH-1:0];
        flags_nxt[1] = sum[WIDTH];
        flags_nxt[0] = (bus.Val_Rn[WIDTH-1] != val2[WIDTH-1]) &&
                       (alu_res[WIDTH-1] != bus.Val_Rn[WIDTH-1]);
      end
      default: op_valid = 1'b0;
    endcase
    if (op_valid) begin
      flags_nxt[3] = alu_res[WIDTH-1];
      flags_nxt[2] = (alu_res == '0);
    end
  end

  // Status register; deliberately not gated by freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= 4'b0000;
    end else if (bus.S_in && !bus.branch_enable_in) begin
      status_q <= flags_nxt;
    end
  end

  // EXE/MEM pipeline register, held while memory stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q     <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      alu_q    <= '0;
      rm_q     <= '0;
      dest_q   <= 4'd0;
    end else if (!bus.freeze) begin
      wb_q     <= bus.wb_enable_in;
      mem_rd_q <= bus.mem_read_enable_in;
      mem_wr_q <= bus.mem_write_enable_in;
      alu_q    <= alu_res;
      rm_q     <= bus.Val_Rm;
      dest_q   <= bus.Dest_in;
    end
  end

  assign bus.status           = status_q;
  assign bus.branch_taken     = bus.branch_enable_in;
  assign bus.branch_address   = bus.PC_in +
                                {{6{bus.Signed_immidiate_24[23]}}, bus.Signed_immidiate_24, 2'b00};
  assign bus.wb_enable        = wb_q;
  assign bus.mem_read_enable  = mem_rd_q;
  assign bus.mem_write_enable = mem_wr_q;
  assign bus.ALU_result       = alu_q;
  assign bus.Val_Rm_out       = rm_q;
  assign bus.Dest             = dest_q;

endmodule
